// File: rtl/apb_sram_slave.sv
// APB slave backed by an internal DEPTH x DATA_W single-port memory, with programmable wait states.
// Optional macro APB_SRAM_PSTRB_EN enables per-byte write strobes; when it is undefined, every write updates the full word.
module apb_sram_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int WAIT_W = 4
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [WAIT_W-1:0]     PWAIT,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W/8-1:0]   PSTRB,
    output logic                  PREADY,
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PSLVERR,
    output logic [1:0]            dbg_state_o
);

    // Handshake: a transfer is sampled in setup (PSEL=1, PENABLE=0). It completes on the
    // single cycle in which PREADY=1 with PSEL=PENABLE=1. PSLVERR and PRDATA are only
    // meaningful while PREADY=1. Dropping PSEL before completion cancels the transfer.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam int SW = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SW-1:0]     strb_q, strb_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;

    logic              enter_ready;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_wr;
    logic              acc_in_range;
    logic              mem_we;

    // A zero-wait transfer enters READY straight from setup, before the capture registers hold it.
    assign acc_addr     = (state_q == S_IDLE) ? PADDR  : addr_q;
    assign acc_wr       = (state_q == S_IDLE) ? PWRITE : wr_q;
    assign acc_in_range = ({1'b0, acc_addr} < DEPTH_C);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        prdata_d    = prdata_q;
        enter_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR;
                    wr_d    = PWRITE;
                    wdata_d = PWDATA;
                    strb_d  = PSTRB;
                    if (PWAIT == '0) begin
                        enter_ready = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = PWAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (PENABLE) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                    if (cnt_q == WAIT_W'(1)) begin
                        enter_ready = 1'b1;
                    end
                end
            end
            S_READY: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (enter_ready) begin
            state_d   = S_READY;
            pready_d  = 1'b1;
            pslverr_d = !acc_in_range;
            if (!acc_in_range) begin
                prdata_d = '0;
            end else if (!acc_wr) begin
                prdata_d = mem[acc_addr];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Writes commit only when the master actually completes the READY cycle.
    assign mem_we = (state_q == S_READY) && PSEL && PENABLE && wr_q && !pslverr_q && !PRESET;

    always_ff @(posedge PCLK) begin
        if (mem_we) begin
`ifdef APB_SRAM_PSTRB_EN
            for (int b = 0; b < SW; b++) begin
                if (strb_q[b]) begin
                    mem[addr_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
`else
            mem[addr_q] <= wdata_q;
`endif
        end
    end

`ifndef APB_SRAM_PSTRB_EN
    logic unused_strb;
    assign unused_strb = ^strb_q;
`endif

    assign PREADY      = pready_q;
    assign PSLVERR     = pslverr_q;
    assign PRDATA      = prdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_sram_slave.sv
// Bench for apb_sram_slave (DEPTH=200): directed cases plus random APB traffic against an array model.
// The monitor pops the expected {PSLVERR, PRDATA} whenever PREADY is seen high.
module tb_apb_sram_slave;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 200;
    localparam int WW    = 4;
    localparam int SW    = DW / 8;
    localparam int EW    = DW + 1;

    logic          PCLK;
    logic          PRESET;
    logic [WW-1:0] PWAIT;
    logic          PSEL;
    logic          PENABLE;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          PSLVERR;
    logic [1:0]    dbg_state;

    apb_sram_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_W(WW)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PWAIT(PWAIT), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR), .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- counters, checker ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [64:0] got, input logic [64:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [0:DEPTH-1];
    logic [DW-1:0] m_prdata;
    logic [EW-1:0] exp_q [$];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = new_w;
`ifdef APB_SRAM_PSTRB_EN
        for (int b = 0; b < SW; b++) begin
            r[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        end
`endif
        return r;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge PCLK) begin
        if (PREADY === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pready", 65'(1), 65'(0));
            end else begin
                chk("resp", 65'({PSLVERR, PRDATA}), 65'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks (entered/left at posedge+1) ----------------
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input int wt, input bit rst_ready);
        int got;
        bit err;
        err = (int'(addr) >= DEPTH);
        if (err) begin
            m_prdata = '0;
            exp_q.push_back({1'b1, {DW{1'b0}}});
        end else if (!wr) begin
            m_prdata = m_mem[addr];
            exp_q.push_back({1'b0, m_prdata});
        end else begin
            exp_q.push_back({1'b0, m_prdata});
            if (!rst_ready) m_mem[addr] = merge(m_mem[addr], data, strb);
        end
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
        PWDATA = data; PSTRB = strb; PWAIT = WW'(wt);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PWAIT = WW'($urandom_range(0, 15));
        got = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge PCLK);
            if (PREADY === 1'b1) begin
                got = k;
                break;
            end
            @(posedge PCLK); #1;
        end
        chk("ready_latency", 65'(got), 65'(wt + 1));
        if (got == 0) begin
            void'(exp_q.pop_back());
        end
        if (rst_ready) PRESET = 1'b1;
        @(posedge PCLK); #1;
        if (rst_ready) begin
            PRESET = 1'b0;
            m_prdata = '0;
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_abort(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int wt, input int n);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr;
        PWDATA = data; PSTRB = '1; PWAIT = WW'(wt);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (n) begin
            @(posedge PCLK); #1;
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        chk("abort_pready", 65'(PREADY), 65'(0));
        chk("abort_state_idle", 65'(dbg_state), 65'(0));
        @(posedge PCLK); #1;
    endtask

    task automatic do_reset(input int cycles);
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
        repeat (cycles) @(posedge PCLK);
        #1 PRESET = 1'b0;
        m_prdata = '0;
        @(negedge PCLK);
        chk("rst_pready", 65'(PREADY), 65'(0));
        chk("rst_pslverr", 65'(PSLVERR), 65'(0));
        chk("rst_prdata", 65'(PRDATA), 65'(0));
        chk("rst_state_idle", 65'(dbg_state), 65'(0));
        @(posedge PCLK); #1;
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; PWAIT = '0;
        m_prdata = '0;
        @(posedge PCLK); #1;
        do_reset(2);

        // Fill memory so every later read has a defined expected value.
        for (int i = 0; i < DEPTH; i++) begin
            apb_xfer(1'b1, AW'(i), DW'($urandom), '1, $urandom_range(0, 2), 1'b0);
        end

        // Zero-wait write then read.
        apb_xfer(1'b1, 8'h10, 32'hDEADBEEF, '1, 0, 1'b0);
        apb_xfer(1'b0, 8'h10, 32'h0, '0, 0, 1'b0);
        // Read with three wait states.
        apb_xfer(1'b0, 8'h10, 32'h0, '0, 3, 1'b0);
        // Out-of-range accesses.
        apb_xfer(1'b1, 8'hF0, 32'h12345678, '1, 1, 1'b0);
        apb_xfer(1'b0, 8'hF0, 32'h0, '0, 0, 1'b0);
        apb_xfer(1'b0, 8'hC8, 32'h0, '0, 2, 1'b0);
        apb_xfer(1'b0, 8'hC7, 32'h0, '0, 0, 1'b0);
        // Byte strobes.
        apb_xfer(1'b1, 8'h30, 32'h11223344, '1, 0, 1'b0);
        apb_xfer(1'b1, 8'h30, 32'hAABBCCDD, 4'b0101, 1, 1'b0);
        apb_xfer(1'b0, 8'h30, 32'h0, '0, 0, 1'b0);
        apb_xfer(1'b1, 8'h31, 32'h55667788, 4'b0000, 0, 1'b0);
        apb_xfer(1'b0, 8'h31, 32'h0, '0, 0, 1'b0);

        // Abort in WAIT, then reset mid-transfer, then normal transfers.
        apb_abort(8'h20, 32'hCAFEF00D, 4, 2);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h20;
        PWDATA = 32'hBAADF00D; PSTRB = '1; PWAIT = 4'd5;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1;
        do_reset(1);
        apb_xfer(1'b0, 8'h20, 32'h0, '0, 0, 1'b0);
        // Reset while in READY blocks the write.
        apb_xfer(1'b1, 8'h21, 32'h0BADBEEF, '1, 0, 1'b1);
        apb_xfer(1'b0, 8'h21, 32'h0, '0, 1, 1'b0);

        // PENABLE without setup is ignored.
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h22;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("noset_pready", 65'(PREADY), 65'(0));
            chk("noset_state_idle", 65'(dbg_state), 65'(0));
        end
        @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
        apb_xfer(1'b0, 8'h22, 32'h0, '0, 0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge PCLK); #1;
            end
            a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 255)) : AW'($urandom_range(0, DEPTH - 1));
            d = DW'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                apb_abort(AW'($urandom_range(0, DEPTH - 1)), d, $urandom_range(2, 6), $urandom_range(0, 1));
            end else begin
                apb_xfer(1'($urandom_range(0, 1)), a, d, SW'($urandom_range(0, 15)),
                         $urandom_range(0, 5), ($urandom_range(0, 29) == 0));
            end
        end

        repeat (5) @(posedge PCLK);
        chk("queue_drained", 65'(exp_q.size()), 65'(0));
        finish_run();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_sram_slave.md
APB_SRAM_SLAVE -- requirements
Module: apb_sram_slave

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits, 8..64.
REQ-002 Parameter ADDR_W, default 8, word-address width in bits.
REQ-003 Parameter DEPTH, default 256, number of words, at most 2**ADDR_W.
REQ-004 Parameter WAIT_W, default 4, width of the wait-state count.
REQ-005 Clocking SHALL be one clock PCLK, all state on its rising edge; reset PRESET is synchronous and active-high.
REQ-006 Port PCLK input 1, the single clock.
REQ-007 Port PRESET input 1, synchronous active-high reset.
REQ-008 Port PWAIT input WAIT_W, wait states inserted per transfer.
REQ-009 Port PSEL input 1, slave select.
REQ-010 Port PENABLE input 1, access-phase marker.
REQ-011 Port PADDR input ADDR_W, word address.
REQ-012 Port PWRITE input 1, 1 = write, 0 = read.
REQ-013 Port PWDATA input DATA_W, write data.
REQ-014 Port PSTRB input DATA_W/8, byte-lane write enables.
REQ-015 Port PREADY output 1, transfer completion, registered.
REQ-016 Port PRDATA output DATA_W, read data, registered.
REQ-017 Port PSLVERR output 1, error response, valid only while PREADY=1.

Function
REQ-018 The FSM SHALL have three states: IDLE, WAIT and READY.
REQ-019 In IDLE, a rising edge with PSEL=1 and PENABLE=0 (setup sample) SHALL capture PADDR, PWRITE, PWDATA and PSTRB; PWAIT=0 -> READY, else WAIT with counter=PWAIT.
REQ-020 In WAIT, each edge with PSEL=1 and PENABLE=1 SHALL decrement the counter; at counter=1 the state SHALL move to READY.
REQ-021 PREADY SHALL be 1 only in READY, so PREADY rises in access cycle PWAIT+1 (zero-wait when PWAIT=0); PWAIT is sampled only at setup.
REQ-022 A read SHALL load PRDATA with mem[captured PADDR] on the edge entering READY; PRDATA SHALL hold its value until the next read completes.
REQ-023 A write SHALL update memory on the edge leaving READY (PSEL=1, PENABLE=1); a read in the next transfer SHALL return the new data.
REQ-024 An address with PADDR >= DEPTH SHALL give PSLVERR=1 with PREADY; the memory SHALL be left unchanged and PRDATA SHALL be loaded with 0.
REQ-025 READY SHALL always return to IDLE after one cycle; back-to-back transfers SHALL be accepted with the next setup directly after completion.
REQ-026 If PSEL=0 in WAIT or READY, the transfer SHALL abort to IDLE with no memory write and PREADY=0 on the next cycle.
REQ-027 PENABLE=1 sampled in IDLE without a prior setup SHALL be ignored, and the FSM SHALL stay in IDLE.
REQ-028 Memory is DEPTH x DATA_W, has a single port, and is internal to the block.

Reset
REQ-029 PRESET=1 at an edge SHALL force IDLE, PREADY=0, PSLVERR=0, PRDATA=0 and counter=0, taking precedence over all other inputs.
REQ-030 A reset during WAIT or READY SHALL abort the transfer with no memory write; memory contents are not cleared.

Configuration
REQ-031 Macro APB_SRAM_PSTRB_EN defined: writes SHALL update only the byte lanes whose PSTRB bit is 1, and PSTRB=0 SHALL leave the word unchanged.
REQ-032 Macro APB_SRAM_PSTRB_EN undefined: PSTRB SHALL be ignored and every write SHALL update the full word.

Verification
REQ-033 Reset then idle: PRESET=1 for 2 cycles -> PREADY=0, PSLVERR=0, PRDATA=0.
REQ-034 Zero-wait write then read: write 0xDEADBEEF to 0x10 with PWAIT=0, read 0x10 with PWAIT=0 -> PREADY in the first access cycle, PRDATA=0xDEADBEEF.
REQ-035 Wait states: read with PWAIT=3 -> PREADY low for 3 access cycles, high on the 4th.
REQ-036 Error: DEPTH=200, access 0xF0 -> PSLVERR=1 with PREADY, PRDATA=0, no write.
REQ-037 Strobe: with APB_SRAM_PSTRB_EN, word 0x11223344 then write 0xAABBCCDD with PSTRB=0101 -> read 0x11BB33DD; without the macro -> read 0xAABBCCDD.
REQ-038 Abort and reset: PSEL dropped in WAIT during a write to 0x20, then PRESET pulsed mid-transfer -> word 0x20 unchanged, FSM in IDLE, next transfer completes normally.
